// File: rtl/bt_cmd_seq_if.sv
// Sequencer <-> command table / UART sender bundle: table lookup plus cmd_start/cmd_len/send/resp_rcvd handshake.
// master = sequencer side, slave = table + sender side.
interface bt_cmd_seq_if #(
  parameter int NUM_CMDS = 4
);
  localparam int IW = $clog2(NUM_CMDS);

  logic [IW-1:0] tbl_idx;
  logic [4:0]    tbl_start;
  logic [3:0]    tbl_len;
  logic [4:0]    cmd_start;
  logic [3:0]    cmd_len;
  logic          send;
  logic          resp_rcvd;

  modport master (
    output tbl_idx, cmd_start, cmd_len, send,
    input  tbl_start, tbl_len, resp_rcvd
  );

  modport slave (
    input  tbl_idx, cmd_start, cmd_len, send,
    output tbl_start, tbl_len, resp_rcvd
  );
endinterface

// File: rtl/bt_cmd_seq.sv
// Walks a command table through the UART sender with a response timeout and inter-command gap; send 2 cycles after start.
// No backpressure beyond the sender's resp_rcvd strobe; `BT_SEQ_RETRY_EN enables per-command re-send on timeout.
module bt_cmd_seq #(
  parameter int NUM_CMDS       = 4,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int GAP_CYCLES     = 50_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  bt_cmd_seq_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int IW = $clog2(NUM_CMDS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CMDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (NUM_CMDS < 2 || TIMEOUT_CYCLES < 2 || GAP_CYCLES < 1 || MAX_RETRY < 0) begin : g_param_check
    $error("bt_cmd_seq: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;
  logic [4:0]    cmd_start_q;
  logic [3:0]    cmd_len_q;
  logic          done_q, err_q;
  logic          accept, resp_hit, timeout, is_last, retry_ok;
  logic          send_c, busy_c;

  assign accept   = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign resp_hit = (state_q == S_WAIT) && bus.resp_rcvd;
  // A response arriving on the timeout cycle takes priority.
  assign timeout  = (state_q == S_WAIT) && !bus.resp_rcvd && (timer_q == TMO_LAST);
  assign is_last  = (idx_q == LAST_IDX);

`ifdef BT_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q;

  assign retry_ok = (retry_q != RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    retry_q <= '0;
    else if (accept || resp_hit)   retry_q <= '0;
    else if (timeout && retry_ok)  retry_q <= retry_q + 1'b1;
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (accept) state_d = S_LOAD;
      S_LOAD:                state_d = S_SEND;
      S_SEND:                state_d = S_WAIT;
      S_WAIT: begin
        if (resp_hit)     state_d = is_last ? S_DONE : S_GAP;
        else if (timeout) state_d = retry_ok ? S_GAP : S_ERR;
      end
      S_GAP:                 if (gap_q == GAP_LAST) state_d = S_LOAD;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    send_c = (state_q == S_SEND);
    busy_c = (state_q inside {S_LOAD, S_SEND, S_WAIT, S_GAP});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
      cmd_start_q <= '0;
      cmd_len_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        idx_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (state_q == S_LOAD) begin
        cmd_start_q <= bus.tbl_start;
        cmd_len_q   <= bus.tbl_len;
      end
      if (state_q == S_SEND) timer_q <= '0;
      if (state_q == S_WAIT) begin
        timer_q <= timer_q + 1'b1;
        gap_q   <= '0;
      end
      if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
      if (resp_hit) begin
        if (is_last) done_q <= 1'b1;
        else         idx_q  <= idx_q + 1'b1;
      end
      if (timeout && !retry_ok) err_q <= 1'b1;
    end
  end

  assign bus.tbl_idx   = idx_q;
  assign bus.cmd_start = cmd_start_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.send      = send_c;
  assign busy          = busy_c;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_bt_cmd_seq.sv
// Bench for bt_cmd_seq: a schedule-level model predicts every cycle of the outputs from the
// command/response timeline; randomized response delays, retries, spurious inputs and reset.
module tb_bt_cmd_seq;
  localparam int NC = 3;
  localparam int T  = 100;
  localparam int G  = 4;
  localparam int MR = 2;
  localparam int L  = 1024;
`ifdef BT_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int F_DONE = 0, F_ERR = 1, F_IDX = 2, F_CS = 3, F_CL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  bt_cmd_seq_if #(.NUM_CMDS(NC)) bus ();

  bt_cmd_seq #(
    .NUM_CMDS(NC), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int tab_s(input int i);
    case (i)
      0: return 0;
      1: return 6;
      2: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int tab_l(input int i);
    case (i)
      0: return 5;
      1: return 3;
      2: return 8;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    bus.tbl_start = 5'(tab_s(int'(bus.tbl_idx)));
    bus.tbl_len   = 4'(tab_l(int'(bus.tbl_idx)));
  end

  int checks = 0;
  int errors = 0;

  // Stimulus plan and expected per-cycle outputs, indexed by cycle within a scenario.
  bit          p_start[L], p_resp[L], p_rst[L];
  bit          e_send[L], e_busy[L], e_done[L], e_err[L];
  int          e_idx[L], e_cs[L], e_cl[L];
  logic [14:0] e_vec[L], o_vec[L];
  int          dly[$];
  int          m_sends[$];
  int          m_gaps[$];
  int          m_end;

  task automatic fill(input int from, input int which, input int val);
    for (int c = from; c < L; c++) begin
      case (which)
        F_DONE: e_done[c] = val[0];
        F_ERR:  e_err[c]  = val[0];
        F_IDX:  e_idx[c]  = val;
        F_CS:   e_cs[c]   = val;
        default: e_cl[c]  = val;
      endcase
    end
  endtask

  task automatic model_clear();
    bit d0 = e_done[L-1];
    bit r0 = e_err[L-1];
    int i0 = e_idx[L-1];
    int s0 = e_cs[L-1];
    int l0 = e_cl[L-1];
    for (int c = 0; c < L; c++) begin
      p_start[c] = 0; p_resp[c] = 0; p_rst[c] = 0;
      e_send[c] = 0;  e_busy[c] = 0;
      e_done[c] = d0; e_err[c] = r0; e_idx[c] = i0; e_cs[c] = s0; e_cl[c] = l0;
    end
    m_sends.delete();
    m_gaps.delete();
    dly.delete();
  endtask

  // dly holds one entry per send attempt: 1..T = response that many cycles after send, 0 = silence.
  task automatic model_build(input int c0);
    int idx = 0, retry = 0, t, s, d, r, tmo;
    bit fin = 0;
    p_start[c0] = 1;
    fill(c0 + 1, F_DONE, 0);
    fill(c0 + 1, F_ERR, 0);
    fill(c0 + 1, F_IDX, 0);
    t = c0 + 1;
    while (!fin) begin
      s = t + 1;
      fill(s, F_CS, tab_s(idx));
      fill(s, F_CL, tab_l(idx));
      e_send[s] = 1;
      m_sends.push_back(s);
      d = (dly.size() > 0) ? dly.pop_front() : 0;
      if (d >= 1 && d <= T) begin
        r = s + d;
        p_resp[r] = 1;
        if (idx == NC - 1) begin
          m_end = r;
          fill(r + 1, F_DONE, 1);
          fin = 1;
        end else begin
          idx++;
          retry = 0;
          fill(r + 1, F_IDX, idx);
          m_gaps.push_back(r + 1);
          t = r + G + 1;
        end
      end else begin
        tmo = s + T;
        if (RETRY_EN && retry < MR) begin
          retry++;
          m_gaps.push_back(tmo + 1);
          t = tmo + G + 1;
        end else begin
          m_end = tmo;
          fill(tmo + 1, F_ERR, 1);
          fin = 1;
        end
      end
    end
    for (int c = c0 + 1; c <= m_end; c++) e_busy[c] = 1;
  endtask

  task automatic model_reset_at(input int rc);
    p_rst[rc] = 1;
    for (int c = rc; c < L; c++) begin
      e_send[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
      e_idx[c] = 0;  e_cs[c] = 0;   e_cl[c] = 0;
      if (c > rc) begin
        p_resp[c] = 0;
        p_start[c] = 0;
      end
    end
    m_end = rc;
  endtask

  task automatic model_pack();
    for (int c = 0; c < L; c++)
      e_vec[c] = {e_send[c], e_busy[c], e_done[c], e_err[c],
                  e_idx[c][1:0], e_cs[c][4:0], e_cl[c][3:0]};
  endtask

  // Entered and left just after a rising edge; inputs change there, outputs sampled 1ns later.
  task automatic run_plan(input int n);
    for (int lc = 0; lc < n; lc++) begin
      start         = p_start[lc];
      bus.resp_rcvd = p_resp[lc];
      rst_n         = !p_rst[lc];
      #1;
      o_vec[lc] = {bus.send, busy, done, err, bus.tbl_idx, bus.cmd_start, bus.cmd_len};
      @(posedge clk);
      #1;
    end
    start = 0;
    bus.resp_rcvd = 0;
    rst_n = 1;
  endtask

  task automatic test_reset();
    bus.resp_rcvd = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.send !== 1'b0)      begin errors++; $display("FAIL reset_send got %b want 0", bus.send); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)           begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (bus.tbl_idx !== 2'd0)   begin errors++; $display("FAIL reset_idx got %0d want 0", bus.tbl_idx); end
    checks++; if (bus.cmd_start !== 5'd0) begin errors++; $display("FAIL reset_cmd_start got %0d want 0", bus.cmd_start); end
    checks++; if (bus.cmd_len !== 4'd0)   begin errors++; $display("FAIL reset_cmd_len got %0d want 0", bus.cmd_len); end
    rst_n = 1;
    @(posedge clk);
    #1;
    checks++; if ({bus.send, busy, done, err} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset got %b want 0000", {bus.send, busy, done, err});
    end
  endtask

  task automatic test_sequence();
    for (int k = 0; k < 3; k++) begin
      int n, shown = 0, nsend = 0;
      model_clear();
      for (int i = 0; i < NC; i++) dly.push_back(int'($urandom_range(1, T)));
      model_build(int'($urandom_range(1, 5)));
      model_pack();
      n = m_end + 6;
      run_plan(n);
      for (int c = 0; c < n; c++) begin
        nsend += int'(o_vec[c][14]);
        checks++;
        if (o_vec[c] !== e_vec[c]) begin
          errors++;
          if (shown++ < 4) $display("FAIL seq_trace run %0d cyc %0d got %h want %h", k, c, o_vec[c], e_vec[c]);
        end
      end
      checks++;
      if (nsend !== NC) begin errors++; $display("FAIL seq_send_count got %0d want %0d", nsend, NC); end
    end
  endtask

  task automatic test_timeout_retry();
    int n, shown = 0, nsend = 0;
    model_clear();
    model_build(3);
    model_pack();
    n = m_end + 6;
    run_plan(n);
    for (int c = 0; c < n; c++) begin
      nsend += int'(o_vec[c][14]);
      checks++;
      if (o_vec[c] !== e_vec[c]) begin
        errors++;
        if (shown++ < 4) $display("FAIL timeout_trace cyc %0d got %h want %h", c, o_vec[c], e_vec[c]);
      end
    end
    checks++;
    if (nsend !== (RETRY_EN ? MR + 1 : 1)) begin
      errors++; $display("FAIL timeout_send_count got %0d want %0d", nsend, RETRY_EN ? MR + 1 : 1);
    end
    checks++;
    if (o_vec[n-1][12:9] !== 4'b0100) begin
      errors++; $display("FAIL timeout_final done/err/idx got %b want 0100", o_vec[n-1][12:9]);
    end
  endtask

  task automatic test_resp_at_timeout();
    int n, shown = 0;
    model_clear();
    dly.push_back(int'($urandom_range(1, T)));
    dly.push_back(T);
    dly.push_back(int'($urandom_range(1, T)));
    model_build(2);
    model_pack();
    n = m_end + 6;
    run_plan(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (o_vec[c] !== e_vec[c]) begin
        errors++;
        if (shown++ < 4) $display("FAIL edge_resp_trace cyc %0d got %h want %h", c, o_vec[c], e_vec[c]);
      end
    end
    checks++;
    if (o_vec[n-1][12:11] !== 2'b10) begin
      errors++; $display("FAIL edge_resp_final done/err got %b want 10", o_vec[n-1][12:11]);
    end
  endtask

  task automatic test_spurious();
    int n, c0, shown = 0;
    model_clear();
    for (int i = 0; i < NC; i++) dly.push_back(int'($urandom_range(1, 40)));
    c0 = 2;
    model_build(c0);
    p_resp[m_gaps[0] + int'($urandom_range(0, G - 1))] = 1;
    p_resp[m_gaps[1] + int'($urandom_range(0, G - 1))] = 1;
    p_resp[m_sends[1]] = 1;
    p_resp[m_end + 3] = 1;
    p_start[int'($urandom_range(c0 + 1, m_end))] = 1;
    p_start[m_sends[2] + 1] = 1;
    model_pack();
    n = m_end + 6;
    run_plan(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (o_vec[c] !== e_vec[c]) begin
        errors++;
        if (shown++ < 4) $display("FAIL spurious_trace cyc %0d got %h want %h", c, o_vec[c], e_vec[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, rc, shown = 0;
    model_clear();
    dly.push_back(int'($urandom_range(1, T)));
    dly.push_back(T);
    model_build(2);
    rc = m_sends[1] + int'($urandom_range(1, T - 1));
    model_reset_at(rc);
    model_pack();
    n = rc + 4;
    run_plan(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (o_vec[c] !== e_vec[c]) begin
        errors++;
        if (shown++ < 4) $display("FAIL reset_mid_trace cyc %0d got %h want %h", c, o_vec[c], e_vec[c]);
      end
    end
    shown = 0;
    model_clear();
    for (int i = 0; i < NC; i++) dly.push_back(int'($urandom_range(1, T)));
    model_build(1);
    model_pack();
    n = m_end + 6;
    run_plan(n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (o_vec[c] !== e_vec[c]) begin
        errors++;
        if (shown++ < 4) $display("FAIL restart_trace cyc %0d got %h want %h", c, o_vec[c], e_vec[c]);
      end
    end
    checks++;
    if (o_vec[m_sends[0]][8:0] !== {5'd0, 4'd5}) begin
      errors++; $display("FAIL restart_first_cmd got %h want %h", o_vec[m_sends[0]][8:0], {5'd0, 4'd5});
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_timeout_retry();
    test_resp_at_timeout();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
